// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter with per-master lock in front of one Avalon-style slave.
// Optional slave-stall timeout abort is compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   m0_address,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic            m0_lock,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_waitrequest,
  input  logic [AW-1:0]   m1_address,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic            m1_lock,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_waitrequest,
  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  input  logic [DW-1:0]   s_readdata,
  input  logic            s_waitrequest,
  output logic            bus_error,
  output logic [1:0]      grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state;
  logic   last;
  logic   m0_req, m1_req, own0, own1, req, lock, timeout;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;
  assign own0   = (state == OWN0);
  assign own1   = (state == OWN1);
  assign req    = (own0 & m0_req) | (own1 & m1_req);
  assign lock   = (own0 & m0_lock) | (own1 & m1_lock);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_cnt;

  // OWN is only ever entered from IDLE, so clearing in IDLE covers the entry case.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE || !s_waitrequest) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign timeout = req & s_waitrequest & (stall_cnt == CW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif

  assign bus_error = timeout;

  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    if (own0) begin
      s_address    = m0_address;
      s_writedata  = m0_writedata;
      s_byteenable = m0_byteenable;
      s_read       = m0_read;
      s_write      = m0_write & ~m0_read;
    end else if (own1) begin
      s_address    = m1_address;
      s_writedata  = m1_writedata;
      s_byteenable = m1_byteenable;
      s_read       = m1_read;
      s_write      = m1_write & ~m1_read;
    end
    if (timeout) begin
      s_read  = 1'b0;
      s_write = 1'b0;
    end
  end

  assign m0_waitrequest = own0 ? (s_waitrequest & ~timeout) : 1'b1;
  assign m1_waitrequest = own1 ? (s_waitrequest & ~timeout) : 1'b1;
  assign m0_readdata    = (own0 & timeout) ? '1 : s_readdata;
  assign m1_readdata    = (own1 & timeout) ? '1 : s_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      grant <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the master that was not served last wins.
          if (m0_req && (!m1_req || last)) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (m1_req) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        default: begin
          if (!req) begin
            state <= IDLE;
            grant <= 2'b00;
          end else if (timeout) begin
            last  <= own1;
            state <= IDLE;
            grant <= 2'b00;
          end else if (!s_waitrequest) begin
            last <= own1;
            if (!lock) begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
      endcase
    end
  end

endmodule
